// File: rtl/vec_chunk_buffer_pkg.sv
// Shared types and sizing helpers for the activation-vector chunk buffer
// and the matrix-vector product stage that consumes its chunks.
package vec_chunk_buffer_pkg;

  localparam int WORKING_REGS = 4;

  typedef logic signed [WORKING_REGS-1:0][7:0] chunk_t;

  typedef enum logic {
    RD_EMPTY   = 1'b0,
    RD_PRESENT = 1'b1
  } rd_state_e;

  function automatic int num_chunks(input int vl, input int wr);
    return (vl + wr - 1) / wr;
  endfunction

  function automatic int idx_w(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/vec_bank.sv
// One storage bank: byte-addressed writes, whole-chunk combinational read.
// Pad lanes of the last chunk are zeroed whenever element 0 is written.
module vec_bank
  import vec_chunk_buffer_pkg::*;
#(
  parameter  int VecLength   = 16,
  parameter  int WorkingRegs = 4,
  localparam int NC          = num_chunks(VecLength, WorkingRegs),
  localparam int TOT         = NC * WorkingRegs,
  localparam int AW          = idx_w(TOT),
  localparam int CW          = idx_w(NC)
) (
  input  logic                                clk_in,
  input  logic                                i_we,
  input  logic [AW-1:0]                       i_waddr,
  input  logic signed [7:0]                   i_wdata,
  input  logic [CW-1:0]                       i_rd_idx,
  output logic signed [WorkingRegs-1:0][7:0]  o_chunk
);

  logic [7:0] r_mem [TOT];

  always_ff @(posedge clk_in) begin
    if (i_we) begin
      r_mem[i_waddr] <= i_wdata;
      if (i_waddr == '0) begin
        for (int j = VecLength; j < TOT; j++) begin
          r_mem[AW'(j)] <= '0;
        end
      end
    end
  end

  always_comb begin
    o_chunk = '0;
    for (int l = 0; l < WorkingRegs; l++) begin
      o_chunk[l] = r_mem[AW'(int'(i_rd_idx) * WorkingRegs + l)];
    end
  end

endmodule

// File: rtl/vec_chunk_buffer.sv
// Double-buffered activation vector store: serial byte fill on one bank,
// chunked re-scannable read of the other.
module vec_chunk_buffer
  import vec_chunk_buffer_pkg::*;
#(
  parameter  int VecLength   = 16,
  parameter  int WorkingRegs = 4,
  localparam int NumChunks   = num_chunks(VecLength, WorkingRegs)
) (
  input  logic                                clk_in,
  input  logic                                rst_in,
  input  logic                                wr_en,
  input  logic signed [7:0]                   wr_data,
  output logic                                wr_ready,
  output logic                                wr_overflow,
  input  logic                                rd_req_chunk,
  input  logic                                rd_ptr_rst,
  input  logic                                rd_release,
  output logic signed [WorkingRegs-1:0][7:0]  rd_data,
  output logic                                rd_vec_ready
);

  localparam int TOT = NumChunks * WorkingRegs;
  localparam int AW  = idx_w(TOT);
  localparam int CW  = idx_w(NumChunks);
  localparam int IW  = idx_w(VecLength);

  localparam logic [IW-1:0] LAST_IDX   = IW'(VecLength - 1);
  localparam logic [CW-1:0] LAST_CHUNK = CW'(NumChunks - 1);

  rd_state_e r_state;
  rd_state_e w_state_nxt;

  logic [1:0]    r_busy;
  logic          r_wr_bank;
  logic          r_rd_bank;
  logic [IW-1:0] r_wr_idx;
  logic [CW-1:0] r_rd_ptr;
  logic          r_ovf;
  logic signed [WorkingRegs-1:0][7:0] r_data;

  logic          w_wr_fire;
  logic          w_wr_last;
  logic          w_release;
  logic          w_handover;
  logic          w_ptr_op;
  logic [1:0]    w_busy_nxt;
  logic [CW-1:0] w_next_ptr;
  logic [CW-1:0] w_sel_idx;
  logic signed [WorkingRegs-1:0][7:0] w_chunk [2];
  logic signed [WorkingRegs-1:0][7:0] w_sel_chunk;

  assign wr_ready     = !r_busy[r_wr_bank];
  assign wr_overflow  = r_ovf;
  assign rd_data      = r_data;
  assign rd_vec_ready = (r_state == RD_PRESENT);

  assign w_wr_fire = wr_en && wr_ready;
  assign w_wr_last = w_wr_fire && (r_wr_idx == LAST_IDX);
  assign w_ptr_op  = rd_vec_ready && (rd_ptr_rst || rd_req_chunk);

  for (genvar b = 0; b < 2; b++) begin : g_bank
    vec_bank #(
      .VecLength   (VecLength),
      .WorkingRegs (WorkingRegs)
    ) u_bank (
      .clk_in   (clk_in),
      .i_we     (w_wr_fire && (r_wr_bank == 1'(b))),
      .i_waddr  (AW'(r_wr_idx)),
      .i_wdata  (wr_data),
      .i_rd_idx (w_sel_idx),
      .o_chunk  (w_chunk[b])
    );
  end

  // Release has priority over a pending handover so the gap is one cycle.
  always_comb begin
    w_state_nxt = r_state;
    w_release   = 1'b0;
    w_handover  = 1'b0;
    unique case (r_state)
      RD_EMPTY: begin
        if (r_busy[r_rd_bank] && !rd_release) begin
          w_handover  = 1'b1;
          w_state_nxt = RD_PRESENT;
        end
      end
      RD_PRESENT: begin
        if (rd_release) begin
          w_release   = 1'b1;
          w_state_nxt = RD_EMPTY;
        end
      end
    endcase
  end

  always_comb begin
    w_next_ptr = (r_rd_ptr == LAST_CHUNK) ? '0 : r_rd_ptr + CW'(1);
    w_sel_idx  = (w_handover || rd_ptr_rst) ? '0 : w_next_ptr;
    w_sel_chunk = w_chunk[r_rd_bank];
    w_busy_nxt = r_busy;
    if (w_wr_last) w_busy_nxt[r_wr_bank] = 1'b1;
    if (w_release) w_busy_nxt[r_rd_bank] = 1'b0;
  end

  always_ff @(posedge clk_in) begin
    if (rst_in) r_state <= RD_EMPTY;
    else        r_state <= w_state_nxt;
  end

  always_ff @(posedge clk_in) begin
    if (rst_in) begin
      r_busy    <= '0;
      r_wr_bank <= 1'b0;
      r_rd_bank <= 1'b0;
      r_wr_idx  <= '0;
      r_rd_ptr  <= '0;
      r_ovf     <= 1'b0;
      r_data    <= '0;
    end else begin
      r_busy <= w_busy_nxt;
      if (w_wr_fire) begin
        if (w_wr_last) begin
          r_wr_idx  <= '0;
          r_wr_bank <= ~r_wr_bank;
        end else begin
          r_wr_idx <= r_wr_idx + IW'(1);
        end
      end
      if (wr_en && !wr_ready) r_ovf <= 1'b1;
      if (w_release) begin
        r_rd_bank <= ~r_rd_bank;
      end else if (w_handover || w_ptr_op) begin
        r_rd_ptr <= w_sel_idx;
        r_data   <= w_sel_chunk;
      end
    end
  end

endmodule
